// File: rtl/execute_stage_pkg.sv
// Shared opcode and combo-operand codes for the 3-bit-opcode CPU execute stage.
package execute_stage_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADV = 3'd0;
    localparam opcode_t OP_BXL = 3'd1;
    localparam opcode_t OP_BST = 3'd2;
    localparam opcode_t OP_JNZ = 3'd3;
    localparam opcode_t OP_BXC = 3'd4;
    localparam opcode_t OP_OUT = 3'd5;
    localparam opcode_t OP_BDV = 3'd6;
    localparam opcode_t OP_CDV = 3'd7;

    localparam logic [2:0] COMBO_A   = 3'd4;
    localparam logic [2:0] COMBO_B   = 3'd5;
    localparam logic [2:0] COMBO_C   = 3'd6;
    localparam logic [2:0] COMBO_BAD = 3'd7;

    // Only these opcodes interpret their operand as a combo operand.
    function automatic logic uses_combo(input opcode_t op);
        return (op == OP_ADV) || (op == OP_BST) || (op == OP_OUT) ||
               (op == OP_BDV) || (op == OP_CDV);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Instruction-in / predictor-feedback / OUT-stream signals between IF, EX and the sink.
interface execute_stage_if;

    logic       instr_valid;
    logic [2:0] opcode_if;
    logic [2:0] operand_if;
    logic       halt_if;
    logic       reg_A_wr_en;
    logic       reg_A_nz;
    logic [2:0] mod_output;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_data;

    modport slave (
        input  instr_valid, opcode_if, operand_if, out_ready,
        output halt_if, reg_A_wr_en, reg_A_nz, mod_output, out_data, out_valid
    );

    modport master (
        output instr_valid, opcode_if, operand_if, out_ready,
        input  halt_if, reg_A_wr_en, reg_A_nz, mod_output, out_data, out_valid
    );

endinterface

// File: rtl/execute_stage_out_fifo.sv
// Small circular FIFO buffering OUT results; synchronous flush, push/pop in one cycle.
module out_fifo #(
    parameter int W_DATA = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [W_DATA-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [W_DATA-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_DATA-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: owns A/B/C, resolves combo operands, feeds the IF predictor and
// buffers OUT results, stalling IF when the output FIFO is full.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int W         = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_regs,
    input  logic [W-1:0]  init_a,
    input  logic [W-1:0]  init_b,
    input  logic [W-1:0]  init_c,
    execute_stage_if.slave bus,
    output logic [W-1:0]  reg_a,
    output logic [W-1:0]  reg_b,
    output logic [W-1:0]  reg_c,
    output logic          illegal_op
);

    localparam logic [W-1:0] W_LIMIT = W'(W);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic         illegal_q, illegal_d;

    logic [W-1:0] combo;
    logic         combo_bad;
    logic [W-1:0] shift_res;
    logic         fifo_full;
    logic         fifo_empty;
    logic         stall;
    logic         exec;
    logic         push;
    logic         pop;

    always_comb begin
        combo     = '0;
        combo_bad = 1'b0;
        case (bus.operand_if)
            COMBO_A:   combo = a_q;
            COMBO_B:   combo = b_q;
            COMBO_C:   combo = c_q;
            COMBO_BAD: combo_bad = 1'b1;
            default:   combo = W'(bus.operand_if);
        endcase
    end

    // Shifting by W or more must give zero rather than rely on operator semantics.
    assign shift_res = (combo >= W_LIMIT) ? '0 : (a_q >> combo);

    // Stall only looks at registered fullness so out_ready never reaches halt_if.
    assign stall = bus.instr_valid & (bus.opcode_if == OP_OUT) & fifo_full;
    assign exec  = bus.instr_valid & ~init_regs & ~stall;
    assign push  = exec & (bus.opcode_if == OP_OUT);
    assign pop   = bus.out_ready & ~fifo_empty;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        illegal_d = illegal_q;
        if (init_regs) begin
            a_d       = init_a;
            b_d       = init_b;
            c_d       = init_c;
            illegal_d = 1'b0;
        end else if (exec) begin
            case (bus.opcode_if)
                OP_ADV:  a_d = shift_res;
                OP_BXL:  b_d = b_q ^ W'(bus.operand_if);
                OP_BST:  b_d = W'(combo[2:0]);
                OP_BXC:  b_d = b_q ^ c_q;
                OP_BDV:  b_d = shift_res;
                OP_CDV:  c_d = shift_res;
                default: ;
            endcase
            if (combo_bad && uses_combo(bus.opcode_if)) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            illegal_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            illegal_q <= illegal_d;
        end
    end

    out_fifo #(
        .W_DATA (3),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (init_regs),
        .push      (push),
        .push_data (combo[2:0]),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (bus.out_data)
    );

    // The fold keeps mod_output nonzero whenever any upper bit of the write data is set.
    assign bus.reg_A_wr_en = exec & (bus.opcode_if == OP_ADV);
    assign bus.mod_output  = bus.reg_A_wr_en
                           ? {shift_res[2:1], shift_res[0] | (|shift_res[W-1:3])}
                           : 3'b000;
    assign bus.reg_A_nz    = |a_q;
    assign bus.halt_if     = stall;
    assign bus.out_valid   = ~fifo_empty;

    assign reg_a      = a_q;
    assign reg_b      = b_q;
    assign reg_c      = c_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against a queue-based reference model.
module tb_execute_stage;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    localparam logic [2:0] ADV = 3'd0, BXL = 3'd1, BST = 3'd2, JNZ = 3'd3;
    localparam logic [2:0] BXC = 3'd4, OUT = 3'd5, BDV = 3'd6, CDV = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_regs;
    logic [W-1:0] init_a, init_b, init_c;
    logic [W-1:0] reg_a, reg_b, reg_c;
    logic         illegal_op;

    execute_stage_if intf ();

    execute_stage #(.W(W), .OUT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_regs  (init_regs),
        .init_a     (init_a),
        .init_b     (init_b),
        .init_c     (init_c),
        .bus        (intf),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .reg_c      (reg_c),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] mA, mB, mC;
    logic [2:0]  mQ[$];
    bit          mIll;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] shr(input logic [31:0] x, input logic [31:0] s);
        return (s >= 32) ? 32'd0 : (x >> s);
    endfunction

    function automatic logic [31:0] comboVal(input logic [2:0] opr);
        if (opr < 3'd4) return {29'd0, opr};
        if (opr == 3'd4) return mA;
        if (opr == 3'd5) return mB;
        if (opr == 3'd6) return mC;
        return 32'd0;
    endfunction

    function automatic logic [2:0] fold(input logic [31:0] v);
        return {v[2:1], v[0] | (v[31:3] != 0)};
    endfunction

    // One cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [2:0] opr,
                                 input bit rdy, input bit ini, input int expMod);
        bit          full, stall, ex, wrA, pop;
        logic [31:0] cv, sh;
        @(negedge clk);
        intf.instr_valid = v;
        intf.opcode_if   = op;
        intf.operand_if  = opr;
        intf.out_ready   = rdy;
        init_regs        = ini;
        #1;
        full  = (mQ.size() == DEPTH);
        stall = v && (op == OUT) && full;
        ex    = v && !ini && !stall;
        cv    = comboVal(opr);
        sh    = shr(mA, cv);
        wrA   = ex && (op == ADV);
        checkOutput("reg_a", reg_a, mA);
        checkOutput("reg_b", reg_b, mB);
        checkOutput("reg_c", reg_c, mC);
        checkOutput("illegal_op", illegal_op, mIll);
        checkOutput("out_valid", intf.out_valid, mQ.size() > 0);
        checkOutput("out_data", intf.out_data, (mQ.size() > 0) ? mQ[0] : 3'd0);
        checkOutput("halt_if", intf.halt_if, stall);
        checkOutput("reg_A_wr_en", intf.reg_A_wr_en, wrA);
        checkOutput("mod_output", intf.mod_output, wrA ? fold(sh) : 3'd0);
        checkOutput("reg_A_nz", intf.reg_A_nz, mA != 0);
        if (expMod >= 0) checkOutput("mod_directed", intf.mod_output, expMod);
        pop = rdy && (mQ.size() > 0);
        if (ini) begin
            mA = init_a; mB = init_b; mC = init_c;
            mQ.delete();
            mIll = 0;
        end else begin
            if (pop) void'(mQ.pop_front());
            if (ex) begin
                case (op)
                    ADV: mA = sh;
                    BXL: mB = mB ^ {29'd0, opr};
                    BST: mB = {29'd0, cv[2:0]};
                    BXC: mB = mB ^ mC;
                    OUT: mQ.push_back(cv[2:0]);
                    BDV: mB = sh;
                    CDV: mC = sh;
                    default: ;
                endcase
                if (opr == 3'd7 && (op == ADV || op == BST || op == OUT || op == BDV || op == CDV))
                    mIll = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic initRegs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        init_a = a; init_b = b; init_c = c;
        applyStimulus(0, ADV, 3'd0, 0, 1, -1);
    endtask

    initial begin
        rst = 1'b1;
        init_regs = 1'b0;
        init_a = '0; init_b = '0; init_c = '0;
        intf.instr_valid = 1'b0;
        intf.opcode_if   = 3'd0;
        intf.operand_if  = 3'd0;
        intf.out_ready   = 1'b0;
        mA = 0; mB = 0; mC = 0; mIll = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_reg_a", reg_a, 0);
        checkOutput("rst_reg_b", reg_b, 0);
        checkOutput("rst_reg_c", reg_c, 0);
        checkOutput("rst_out_valid", intf.out_valid, 0);
        checkOutput("rst_out_data", intf.out_data, 0);
        checkOutput("rst_illegal", illegal_op, 0);
        checkOutput("rst_halt", intf.halt_if, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ADV scenarios");
        initRegs(729, 0, 0);
        applyStimulus(1, ADV, 3'd1, 0, 0, 5);
        checkOutput("adv729", reg_a, 364);
        initRegs(8, 0, 0);
        applyStimulus(1, ADV, 3'd3, 0, 0, 1);
        checkOutput("adv8", reg_a, 1);
        applyStimulus(1, ADV, 3'd1, 0, 0, 0);
        checkOutput("adv_to_zero", reg_a, 0);

        $display("[TB] B register ops and OUT");
        initRegs(2024, 0, 5);
        applyStimulus(1, BST, 3'd4, 0, 0, -1);
        checkOutput("bst", reg_b, 0);
        applyStimulus(1, BXL, 3'd7, 0, 0, -1);
        checkOutput("bxl", reg_b, 7);
        applyStimulus(1, BXC, 3'd0, 0, 0, -1);
        checkOutput("bxc", reg_b, 2);
        applyStimulus(1, OUT, 3'd5, 0, 0, -1);
        checkOutput("out_b", intf.out_data, 2);
        applyStimulus(0, ADV, 3'd0, 1, 0, -1);

        $display("[TB] FIFO back-pressure");
        initRegs(4, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, OUT, 3'(k), 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, OUT, 3'd4, 0, 0, -1);
            checkOutput("stall_halt", intf.halt_if, 1);
            checkOutput("stall_hold_a", reg_a, 4);
        end
        applyStimulus(1, OUT, 3'd4, 1, 0, -1);
        checkOutput("resume_halt", intf.halt_if, 0);
        applyStimulus(1, OUT, 3'd4, 0, 0, -1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("fifo_order", intf.out_data, k);
            applyStimulus(0, ADV, 3'd0, 1, 0, -1);
        end
        checkOutput("fifo_drained", intf.out_valid, 0);

        $display("[TB] illegal combo operand");
        initRegs(100, 3, 9);
        applyStimulus(1, OUT, 3'd7, 0, 0, -1);
        checkOutput("illegal_set", illegal_op, 1);
        checkOutput("illegal_push", intf.out_data, 0);
        applyStimulus(1, BXL, 3'd3, 0, 0, -1);
        checkOutput("illegal_sticky", illegal_op, 1);
        initRegs(40, 0, 0);
        checkOutput("illegal_clear", illegal_op, 0);
        applyStimulus(1, ADV, 3'd4, 0, 0, 0);
        checkOutput("adv_big_shift", reg_a, 0);

        $display("[TB] async reset with queued entries");
        initRegs(7, 1, 2);
        for (int k = 1; k <= 3; k++) applyStimulus(1, OUT, 3'(k), 0, 0, -1);
        @(negedge clk);
        intf.instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_out_valid", intf.out_valid, 0);
        checkOutput("async_reg_a", reg_a, 0);
        mA = 0; mB = 0; mC = 0; mIll = 0; mQ.delete();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            bit ini;
            ini = ($urandom_range(39, 0) == 0);
            if (ini) begin
                init_a = $urandom_range(1, 0) ? $urandom : $urandom_range(5000, 0);
                init_b = $urandom_range(300, 0);
                init_c = $urandom;
            end
            applyStimulus($urandom_range(3, 0) != 0, 3'($urandom), 3'($urandom),
                          $urandom_range(1, 0) == 1, ini, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
